// File: rtl/sensor_condicionador_if.sv
// Pin bundle between the board sensor contacts and the conditioning stage.
// The master side drives the raw contacts; the slave side returns the debounced levels and status.
interface sensor_condicionador_if;
    logic H_raw, M_raw, L_raw, Us_raw, Ua_raw, T_raw;
    logic H, M, L, Us, Ua, T;
    logic valid;
    logic changed;
    logic tick;

    modport master (
        output H_raw, M_raw, L_raw, Us_raw, Ua_raw, T_raw,
        input  H, M, L, Us, Ua, T, valid, changed, tick
    );

    modport slave (
        input  H_raw, M_raw, L_raw, Us_raw, Ua_raw, T_raw,
        output H, M, L, Us, Ua, T, valid, changed, tick
    );
endinterface

// File: rtl/sensor_condicionador.sv
// Sensor conditioning: two-flop synchronizer, sample tick, startup priming and
// per-contact debounce. Vector order everywhere is {H,M,L,Us,Ua,T}.
module sensor_condicionador #(
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned DEB_CNT  = 4
) (
    input  logic                   clock,
    input  logic                   Rst,
    sensor_condicionador_if.slave  bus
);

    localparam int unsigned NS = 6;
    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CW = $clog2(DEB_CNT) + 1;

    typedef enum logic {PRIME, RUN} state_t;

    logic [NS-1:0]         raw;
    logic [NS-1:0]         sync1_q, s;
    logic [TW-1:0]         div_q, div_d;
    logic                  tick_q, tick_d;
    state_t                state_q, state_d;
    logic [CW-1:0]         run_q, run_d, run_inc;
    logic [NS-1:0]         snap_q, snap_d;
    logic [NS-1:0]         out_q, out_d;
    logic                  valid_q, valid_d;
    logic                  changed_q, changed_d;
    logic [NS-1:0][CW-1:0] cnt_q, cnt_d;

    assign raw = {bus.H_raw, bus.M_raw, bus.L_raw, bus.Us_raw, bus.Ua_raw, bus.T_raw};

    // Two-stage synchronizer; s is the sampled view of the contacts
    always_ff @(posedge clock or posedge Rst) begin
        if (Rst) begin
            sync1_q <= '0;
            s       <= '0;
        end else begin
            sync1_q <= raw;
            s       <= sync1_q;
        end
    end

    // tick is registered so it lines up with the cycle where div_q sits at TICK_DIV-1
    always_comb begin
        div_d  = (div_q == TW'(TICK_DIV - 1)) ? '0 : div_q + TW'(1);
        tick_d = (div_d == TW'(TICK_DIV - 1));
    end

    always_ff @(posedge clock or posedge Rst) begin
        if (Rst) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    always_ff @(posedge clock or posedge Rst) begin
        if (Rst) begin
            state_q   <= PRIME;
            run_q     <= '0;
            snap_q    <= '0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            snap_q    <= snap_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            changed_q <= changed_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        run_inc   = '0;
        snap_d    = snap_q;
        out_d     = out_q;
        valid_d   = valid_q;
        changed_d = 1'b0;
        cnt_d     = cnt_q;

        case (state_q)
            PRIME: begin
                // Wait for DEB_CNT identical consecutive samples of the whole set
                if (tick_q) begin
                    run_inc = (run_q == '0 || s == snap_q) ? run_q + CW'(1) : CW'(1);
                    snap_d  = s;
                    if (run_inc == CW'(DEB_CNT)) begin
                        out_d   = s;
                        valid_d = 1'b1;
                        run_d   = '0;
                        state_d = RUN;
                    end else begin
                        run_d = run_inc;
                    end
                end
            end
            RUN: begin
                if (tick_q) begin
                    for (int i = 0; i < NS; i++) begin
                        if (s[i] == out_q[i]) begin
                            cnt_d[i] = '0;
                        end else if (cnt_q[i] == CW'(DEB_CNT - 1)) begin
                            out_d[i]  = s[i];
                            cnt_d[i]  = '0;
                            changed_d = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CW'(1);
                        end
                    end
                end
            end
            default: state_d = PRIME;
        endcase
    end

    assign {bus.H, bus.M, bus.L, bus.Us, bus.Ua, bus.T} = out_q;
    assign bus.valid   = valid_q;
    assign bus.changed = changed_q;
    assign bus.tick    = tick_q;

endmodule
